// File: rtl/addsub_pkg.sv
// rtl/addsub_pkg.sv - shared types and arithmetic helper for the add/subtract arbiter
package addsub_pkg;

   // Operand storage is sized for the widest supported configuration
   localparam int MAX_OPND_W = 32;
   localparam int MAX_ID_W   = 3;

   typedef enum logic [1:0] {IDLE, EXEC, RESP} state_t;
   typedef enum logic {OP_ADD = 1'b0, OP_SUB = 1'b1} op_t;

   typedef struct packed {
      logic signed [MAX_OPND_W-1:0] a;
      logic signed [MAX_OPND_W-1:0] b;
      op_t                          op;
      logic [MAX_ID_W-1:0]          id;
   } op_req_t;

   function automatic logic signed [2*MAX_OPND_W-1:0] addsub(
      input logic signed [MAX_OPND_W-1:0] a,
      input logic signed [MAX_OPND_W-1:0] b,
      input op_t                          op
   );
      logic signed [2*MAX_OPND_W-1:0] ea;
      logic signed [2*MAX_OPND_W-1:0] eb;
      ea = a;
      eb = b;
      return (op == OP_SUB) ? (ea - eb) : (ea + eb);
   endfunction

endpackage

// File: rtl/rr_arbiter.sv
// rtl/rr_arbiter.sv - combinational round-robin arbiter, search starts at ptr
module rr_arbiter #(
   parameter int N     = 4,
   parameter int IDX_W = $clog2(N)
) (
   input  logic [N-1:0]     req,
   input  logic [IDX_W-1:0] ptr,
   input  logic             en,
   output logic [N-1:0]     grant,
   output logic [IDX_W-1:0] grant_idx
);

   logic found;
   int   k;

   always_comb begin
      grant     = '0;
      grant_idx = '0;
      found     = 1'b0;
      k         = 0;
      for (int i = 0; i < N; i++) begin
         k = int'(ptr) + i;
         if (k >= N) k = k - N;
         if (en && !found && req[k]) begin
            found     = 1'b1;
            grant[k]  = 1'b1;
            grant_idx = IDX_W'(k);
         end
      end
   end

endmodule

// File: rtl/addsub_arbiter.sv
// rtl/addsub_arbiter.sv - round-robin shared signed add/subtract unit
// Optional per-requester grant counters under ADDSUB_ARB_STATS_EN.
module addsub_arbiter
   import addsub_pkg::*;
#(
   parameter int NUM_REQ = 4,
   parameter int BITS    = 16,
   parameter int ID_W    = $clog2(NUM_REQ)
) (
   input  logic                      clk,
   input  logic                      rst_n,
   input  logic [NUM_REQ-1:0]        req_valid,
   output logic [NUM_REQ-1:0]        req_ready,
   input  logic [NUM_REQ*BITS/2-1:0] req_a,
   input  logic [NUM_REQ*BITS/2-1:0] req_b,
   input  logic [NUM_REQ-1:0]        req_op,
   output logic                      rsp_valid,
   input  logic                      rsp_ready,
   output logic [ID_W-1:0]           rsp_id,
`ifdef ADDSUB_ARB_STATS_EN
   input  logic                      stats_clr,
   output logic [NUM_REQ*16-1:0]     grant_cnt,
`endif
   output logic [BITS-1:0]           rsp_result
);

   localparam int OPND_W = BITS / 2;

   state_t              state, state_nxt;
   logic [ID_W-1:0]     ptr;
   op_req_t             op_q;
   logic [NUM_REQ-1:0]  grant;
   logic [ID_W-1:0]     grant_idx;
   logic                arb_en;
   logic                accept;

   // Gating with rst_n keeps ready low while reset is held
   assign arb_en    = rst_n && (state == IDLE);
   assign accept    = |grant;
   assign req_ready = grant;

   rr_arbiter #(.N(NUM_REQ), .IDX_W(ID_W)) u_arb (
      .req       (req_valid),
      .ptr       (ptr),
      .en        (arb_en),
      .grant     (grant),
      .grant_idx (grant_idx)
   );

   always_comb begin
      state_nxt = state;
      rsp_valid = 1'b0;
      case (state)
         IDLE: if (accept) state_nxt = EXEC;
         EXEC: state_nxt = RESP;
         RESP: begin
            rsp_valid = 1'b1;
            if (rsp_ready) state_nxt = IDLE;
         end
         default: state_nxt = IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state      <= IDLE;
         ptr        <= '0;
         op_q       <= '0;
         rsp_id     <= '0;
         rsp_result <= '0;
      end else begin
         state <= state_nxt;
         if (accept) begin
            ptr     <= (grant_idx == ID_W'(NUM_REQ - 1)) ? '0 : grant_idx + ID_W'(1);
            op_q.a  <= MAX_OPND_W'($signed(req_a[grant_idx*OPND_W +: OPND_W]));
            op_q.b  <= MAX_OPND_W'($signed(req_b[grant_idx*OPND_W +: OPND_W]));
            op_q.op <= op_t'(req_op[grant_idx]);
            op_q.id <= MAX_ID_W'(grant_idx);
         end
         if (state == EXEC) begin
            rsp_result <= BITS'(addsub(op_q.a, op_q.b, op_q.op));
            rsp_id     <= ID_W'(op_q.id);
         end
      end
   end

`ifdef ADDSUB_ARB_STATS_EN
   logic [15:0] cnt_q [NUM_REQ];

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         for (int i = 0; i < NUM_REQ; i++) cnt_q[i] <= '0;
      end else begin
         for (int i = 0; i < NUM_REQ; i++) begin
            if (stats_clr)
               cnt_q[i] <= '0;
            else if (grant[i] && cnt_q[i] != 16'hFFFF)
               cnt_q[i] <= cnt_q[i] + 16'd1;
         end
      end
   end

   always_comb begin
      grant_cnt = '0;
      for (int i = 0; i < NUM_REQ; i++) grant_cnt[i*16 +: 16] = cnt_q[i];
   end
`endif

   // Requesters must hold valid and operands until granted
   for (genvar g = 0; g < NUM_REQ; g++) begin : g_req_chk
      a_hold : assert property (@(posedge clk) disable iff (!rst_n)
         req_valid[g] && !req_ready[g] |=> req_valid[g]
            && $stable(req_a[g*OPND_W +: OPND_W])
            && $stable(req_b[g*OPND_W +: OPND_W])
            && $stable(req_op[g]));
   end

endmodule

// File: tb/tb_addsub_arbiter.sv
// tb/tb_addsub_arbiter.sv - directed self-checking bench for addsub_arbiter
module tb_addsub_arbiter;

   logic        clk;
   logic        rst_n;
   logic [3:0]  req_valid;
   logic [3:0]  req_ready;
   logic [31:0] req_a;
   logic [31:0] req_b;
   logic [3:0]  req_op;
   logic        rsp_valid;
   logic        rsp_ready;
   logic [1:0]  rsp_id;
   logic [15:0] rsp_result;
`ifdef ADDSUB_ARB_STATS_EN
   logic        stats_clr;
   logic [63:0] grant_cnt;
`endif

   int checks = 0;
   int errors = 0;
   int cyc    = 0;

   addsub_arbiter #(.NUM_REQ(4), .BITS(16)) dut (
      .clk        (clk),
      .rst_n      (rst_n),
      .req_valid  (req_valid),
      .req_ready  (req_ready),
      .req_a      (req_a),
      .req_b      (req_b),
      .req_op     (req_op),
      .rsp_valid  (rsp_valid),
      .rsp_ready  (rsp_ready),
      .rsp_id     (rsp_id),
`ifdef ADDSUB_ARB_STATS_EN
      .stats_clr  (stats_clr),
      .grant_cnt  (grant_cnt),
`endif
      .rsp_result (rsp_result)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;
   always @(posedge clk) cyc <= cyc + 1;

   task automatic set_req(input int i, input logic [7:0] a, input logic [7:0] b, input logic op);
      req_valid[i]      = 1'b1;
      req_a[i*8 +: 8]   = a;
      req_b[i*8 +: 8]   = b;
      req_op[i]         = op;
   endtask

   task automatic clr_req(input int i);
      req_valid[i] = 1'b0;
   endtask

   task automatic test_reset;
      rst_n = 1'b0;
      @(negedge clk);
      set_req(0, 8'd1, 8'd1, 1'b0);
      #1;
      checks++;
      if (req_ready !== 4'b0000) begin errors++; $display("FAIL reset_ready: got %b exp 0000", req_ready); end
      checks++;
      if (rsp_valid !== 1'b0) begin errors++; $display("FAIL reset_rsp_valid: got %b exp 0", rsp_valid); end
      checks++;
      if (rsp_id !== 2'd0) begin errors++; $display("FAIL reset_rsp_id: got %0d exp 0", rsp_id); end
      checks++;
      if (rsp_result !== 16'h0000) begin errors++; $display("FAIL reset_rsp_result: got %h exp 0000", rsp_result); end
      clr_req(0);
      @(negedge clk);
      rst_n = 1'b1;
   endtask

   task automatic test_single_add;
      @(negedge clk);
      rsp_ready = 1'b1;
      set_req(0, 8'd100, 8'd27, 1'b0);
      #1;
      checks++;
      if (req_ready !== 4'b0001) begin errors++; $display("FAIL add_ready: got %b exp 0001", req_ready); end
      @(negedge clk);
      clr_req(0);
      #1;
      checks++;
      if (rsp_valid !== 1'b0) begin errors++; $display("FAIL add_exec_valid: got %b exp 0", rsp_valid); end
      @(negedge clk);
      #1;
      checks++;
      if (rsp_valid !== 1'b1) begin errors++; $display("FAIL add_rsp_valid: got %b exp 1", rsp_valid); end
      checks++;
      if (rsp_result !== 16'd127) begin errors++; $display("FAIL add_result: got %h exp 007f", rsp_result); end
      checks++;
      if (rsp_id !== 2'd0) begin errors++; $display("FAIL add_id: got %0d exp 0", rsp_id); end
      @(negedge clk);
      #1;
      checks++;
      if (rsp_valid !== 1'b0) begin errors++; $display("FAIL add_rsp_drop: got %b exp 0", rsp_valid); end
   endtask

   task automatic test_sub_extreme;
      @(negedge clk);
      set_req(2, 8'h80, 8'h7F, 1'b1);
      #1;
      checks++;
      if (req_ready !== 4'b0100) begin errors++; $display("FAIL sub_ready: got %b exp 0100", req_ready); end
      @(negedge clk);
      clr_req(2);
      @(negedge clk);
      #1;
      checks++;
      if (rsp_result !== 16'hFF01) begin errors++; $display("FAIL sub_result: got %h exp ff01", rsp_result); end
      checks++;
      if (rsp_id !== 2'd2) begin errors++; $display("FAIL sub_id: got %0d exp 2", rsp_id); end
      @(negedge clk);
   endtask

   task automatic test_backpressure;
      @(negedge clk);
      rsp_ready = 1'b0;
      set_req(3, 8'd50, 8'hEC, 1'b0);
      set_req(0, 8'd1, 8'd2, 1'b1);
      #1;
      checks++;
      if (req_ready !== 4'b1000) begin errors++; $display("FAIL bp_ready: got %b exp 1000", req_ready); end
      @(negedge clk);
      clr_req(3);
      @(negedge clk);
      for (int j = 0; j < 5; j++) begin
         #1;
         checks++;
         if ({rsp_valid, rsp_id, rsp_result} !== {1'b1, 2'd3, 16'h001E}) begin
            errors++;
            $display("FAIL bp_hold%0d: got v=%b id=%0d r=%h exp v=1 id=3 r=001e", j, rsp_valid, rsp_id, rsp_result);
         end
         checks++;
         if (req_ready !== 4'b0000) begin errors++; $display("FAIL bp_no_ready%0d: got %b exp 0000", j, req_ready); end
         if (j < 4) @(negedge clk);
      end
      rsp_ready = 1'b1;
      @(negedge clk);
      rsp_ready = 1'b0;
      #1;
      checks++;
      if (rsp_valid !== 1'b0) begin errors++; $display("FAIL bp_release: got %b exp 0", rsp_valid); end
      checks++;
      if (req_ready !== 4'b0001) begin errors++; $display("FAIL bp_next_grant: got %b exp 0001", req_ready); end
      @(negedge clk);
      clr_req(0);
      @(negedge clk);
      #1;
      checks++;
      if ({rsp_valid, rsp_id, rsp_result} !== {1'b1, 2'd0, 16'hFFFF}) begin
         errors++;
         $display("FAIL bp_second: got v=%b id=%0d r=%h exp v=1 id=0 r=ffff", rsp_valid, rsp_id, rsp_result);
      end
      rsp_ready = 1'b1;
      @(negedge clk);
   endtask

   task automatic test_round_robin;
      logic [15:0] rr_exp [4];
      logic [3:0]  exp_ready;
      int          exp_id;
      int          last;
      int          n;
      rr_exp[0] = 16'h0008;
      rr_exp[1] = 16'hFFF7;
      rr_exp[2] = 16'h00FE;
      rr_exp[3] = 16'hFF00;
      last = 0;
      @(negedge clk);
      rst_n = 1'b0;
      @(negedge clk);
      rst_n     = 1'b1;
      rsp_ready = 1'b1;
      set_req(0, 8'd5,   8'd3,   1'b0);
      set_req(1, 8'hF9,  8'd2,   1'b1);
      set_req(2, 8'd127, 8'd127, 1'b0);
      set_req(3, 8'h80,  8'h80,  1'b0);
      #1;
      for (int k = 0; k < 6; k++) begin
         exp_id    = k % 4;
         exp_ready = 4'b0001 << exp_id;
         n = 0;
         if (k > 0) begin @(negedge clk); #1; end
         while (req_ready === 4'b0000 && n < 10) begin @(negedge clk); #1; n++; end
         checks++;
         if (req_ready !== exp_ready) begin errors++; $display("FAIL rr_grant%0d: got %b exp %b", k, req_ready, exp_ready); end
         if (k > 0) begin
            checks++;
            if (cyc - last != 3) begin errors++; $display("FAIL rr_spacing%0d: got %0d exp 3", k, cyc - last); end
         end
         last = cyc;
         @(negedge clk);
         if (k >= 2) clr_req(exp_id);
         @(negedge clk);
         #1;
         checks++;
         if ({rsp_valid, rsp_id, rsp_result} !== {1'b1, 2'(exp_id), rr_exp[exp_id]}) begin
            errors++;
            $display("FAIL rr_rsp%0d: got v=%b id=%0d r=%h exp v=1 id=%0d r=%h", k, rsp_valid, rsp_id, rsp_result, exp_id, rr_exp[exp_id]);
         end
      end
   endtask

   task automatic test_reset_mid_op;
      @(negedge clk);
      set_req(1, 8'd20, 8'd30, 1'b1);
      #1;
      checks++;
      if (req_ready !== 4'b0010) begin errors++; $display("FAIL rst_first_grant: got %b exp 0010", req_ready); end
      @(negedge clk);
      set_req(3, 8'd3, 8'd4, 1'b0);
      rst_n = 1'b0;
      #1;
      checks++;
      if ({rsp_valid, req_ready, rsp_id, rsp_result} !== {1'b0, 4'b0000, 2'd0, 16'h0000}) begin
         errors++;
         $display("FAIL rst_outputs: got v=%b rdy=%b id=%0d r=%h exp all zero", rsp_valid, req_ready, rsp_id, rsp_result);
      end
      @(negedge clk);
      rst_n = 1'b1;
      #1;
      checks++;
      if (req_ready !== 4'b0010) begin errors++; $display("FAIL rst_ptr_zero: got %b exp 0010", req_ready); end
      checks++;
      if (rsp_valid !== 1'b0) begin errors++; $display("FAIL rst_no_rsp0: got %b exp 0", rsp_valid); end
      @(negedge clk);
      clr_req(1);
      #1;
      checks++;
      if (rsp_valid !== 1'b0) begin errors++; $display("FAIL rst_no_rsp1: got %b exp 0", rsp_valid); end
      @(negedge clk);
      #1;
      checks++;
      if ({rsp_valid, rsp_id, rsp_result} !== {1'b1, 2'd1, 16'hFFF6}) begin
         errors++;
         $display("FAIL rst_rsp: got v=%b id=%0d r=%h exp v=1 id=1 r=fff6", rsp_valid, rsp_id, rsp_result);
      end
      @(negedge clk);
      #1;
      checks++;
      if (req_ready !== 4'b1000) begin errors++; $display("FAIL rst_wrap_grant: got %b exp 1000", req_ready); end
      @(negedge clk);
      clr_req(3);
      @(negedge clk);
      #1;
      checks++;
      if ({rsp_id, rsp_result} !== {2'd3, 16'h0007}) begin
         errors++;
         $display("FAIL rst_req3_rsp: got id=%0d r=%h exp id=3 r=0007", rsp_id, rsp_result);
      end
      @(negedge clk);
   endtask

`ifdef ADDSUB_ARB_STATS_EN
   task automatic test_stats;
      @(negedge clk);
      rst_n = 1'b0;
      @(negedge clk);
      rst_n = 1'b1;
      for (int k = 0; k < 3; k++) begin
         @(negedge clk);
         set_req(1, 8'd1, 8'd1, 1'b0);
         @(negedge clk);
         clr_req(1);
         @(negedge clk);
         @(negedge clk);
      end
      #1;
      checks++;
      if (grant_cnt[31:16] !== 16'd3) begin errors++; $display("FAIL stats_cnt1: got %0d exp 3", grant_cnt[31:16]); end
      checks++;
      if (grant_cnt[15:0] !== 16'd0) begin errors++; $display("FAIL stats_cnt0: got %0d exp 0", grant_cnt[15:0]); end
      @(negedge clk);
      stats_clr = 1'b1;
      set_req(1, 8'd1, 8'd1, 1'b0);
      #1;
      checks++;
      if (req_ready !== 4'b0010) begin errors++; $display("FAIL stats_grant: got %b exp 0010", req_ready); end
      @(negedge clk);
      stats_clr = 1'b0;
      clr_req(1);
      #1;
      checks++;
      if (grant_cnt[31:16] !== 16'd0) begin errors++; $display("FAIL stats_clr_prio: got %0d exp 0", grant_cnt[31:16]); end
      @(negedge clk);
      @(negedge clk);
   endtask
`endif

   initial begin
      rst_n     = 1'b0;
      req_valid = '0;
      req_a     = '0;
      req_b     = '0;
      req_op    = '0;
      rsp_ready = 1'b0;
`ifdef ADDSUB_ARB_STATS_EN
      stats_clr = 1'b0;
`endif
      test_reset;
      test_single_add;
      test_sub_extreme;
      test_backpressure;
      test_round_robin;
      test_reset_mid_op;
`ifdef ADDSUB_ARB_STATS_EN
      test_stats;
`endif
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

   initial begin
      #100000;
      $display("FAIL watchdog: simulation did not complete within time limit");
      $fatal(1);
   end

endmodule
